// File: rtl/systolic_pkg.sv
// Shared types for the systolic sequencer: FSM state encoding and drain length helper.
package systolic_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CLEAR = 3'd1,
    ST_FEED  = 3'd2,
    ST_DRAIN = 3'd3,
    ST_DONE  = 3'd4
  } seq_state_e;

  // Cycles for the last operand wavefront to cross an S x S array.
  function automatic int DRAIN_LEN(input int s);
    return 2 * s - 1;
  endfunction

endpackage

// File: rtl/seq_down_cnt.sv
// Loadable down counter: load wins over decrement, holds at zero, flags terminal count.
module seq_down_cnt #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  input  logic         i_dec,
  output logic         o_zero
);

  logic [W-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (i_dec && (r_cnt != '0)) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/systolic_seq_ctrl.sv
// Systolic array job sequencer: clear PEs, stream k_len operand beats, wait out the drain,
// pulse done. Defining SYS_SEQ_STALL_EN adds a stall input that freezes FEED/DRAIN.
//   state | meaning
//   IDLE  | waiting for start with nonzero k_len
//   CLEAR | one-cycle PE accumulator clear
//   FEED  | reading operand beats 0..k_len-1
//   DRAIN | 2*S-1 cycles for the last wavefront to leave the array
//   DONE  | one-cycle completion pulse
module systolic_seq_ctrl
  import systolic_pkg::*;
#(
  parameter int N  = 2,
  parameter int S  = 4,
  parameter int KW = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [KW-1:0]  k_len,
  input  logic [S*N-1:0] a_vec,
  input  logic [S*N-1:0] b_vec,
`ifdef SYS_SEQ_STALL_EN
  input  logic           stall,
`endif
  output logic           rd_en,
  output logic [KW-1:0]  rd_addr,
  output logic [S*N-1:0] feed_a,
  output logic [S*N-1:0] feed_b,
  output logic           pe_clr,
  output logic           busy,
  output logic           done
);

  localparam int            DW         = $clog2(2 * S);
  localparam logic [DW-1:0] DRAIN_LAST = DW'(DRAIN_LEN(S) - 1);

  seq_state_e    r_state;
  logic          r_busy;
  logic          r_pe_clr;
  logic          r_done;
  logic          r_feed;
  logic          r_valid;
  logic [KW-1:0] r_rd_addr;

  logic w_stall;
  logic w_accept;
  logic w_feed_dec;
  logic w_drain_dec;
  logic w_feed_zero;
  logic w_drain_zero;

`ifdef SYS_SEQ_STALL_EN
  assign w_stall = stall;
`else
  assign w_stall = 1'b0;
`endif

  assign w_accept    = (r_state == ST_IDLE) && start && (k_len != '0);
  assign w_feed_dec  = (r_state == ST_FEED) && !w_stall;
  assign w_drain_dec = (r_state == ST_DRAIN) && !w_stall;

  // Feed counter holds k_len-1 from acceptance, so it doubles as the latched job length.
  seq_down_cnt #(.W(KW)) u_feed_cnt (
    .clk       (clk),
    .rst       (rst),
    .i_load    (w_accept),
    .i_load_val(k_len - 1'b1),
    .i_dec     (w_feed_dec),
    .o_zero    (w_feed_zero)
  );

  seq_down_cnt #(.W(DW)) u_drain_cnt (
    .clk       (clk),
    .rst       (rst),
    .i_load    (r_state == ST_CLEAR),
    .i_load_val(DRAIN_LAST),
    .i_dec     (w_drain_dec),
    .o_zero    (w_drain_zero)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= ST_IDLE;
      r_busy    <= 1'b0;
      r_pe_clr  <= 1'b0;
      r_done    <= 1'b0;
      r_feed    <= 1'b0;
      r_rd_addr <= '0;
    end else begin
      r_pe_clr <= 1'b0;
      r_done   <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_state  <= ST_CLEAR;
            r_busy   <= 1'b1;
            r_pe_clr <= 1'b1;
          end
        end
        ST_CLEAR: begin
          r_state   <= ST_FEED;
          r_feed    <= 1'b1;
          r_rd_addr <= '0;
        end
        ST_FEED: begin
          if (!w_stall) begin
            if (w_feed_zero) begin
              r_state   <= ST_DRAIN;
              r_feed    <= 1'b0;
              r_rd_addr <= '0;
            end else begin
              r_rd_addr <= r_rd_addr + 1'b1;
            end
          end
        end
        ST_DRAIN: begin
          if (!w_stall && w_drain_zero) begin
            r_state <= ST_DONE;
            r_done  <= 1'b1;
          end
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
          r_feed  <= 1'b0;
        end
      endcase
    end
  end

  // Operand buffer answers one cycle after the strobe; r_valid marks that cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_valid <= 1'b0;
    end else begin
      r_valid <= rd_en;
    end
  end

  assign rd_en   = r_feed && !w_stall;
  assign rd_addr = r_rd_addr;
  assign feed_a  = r_valid ? a_vec : '0;
  assign feed_b  = r_valid ? b_vec : '0;
  assign pe_clr  = r_pe_clr;
  assign busy    = r_busy;
  assign done    = r_done;

endmodule

// File: tb/tb_systolic_seq_ctrl.sv
// Bench for systolic_seq_ctrl: randomized jobs, an event-level job model fills scoreboard
// queues, and a negedge monitor pops and compares whenever the DUT presents an output.
module tb_systolic_seq_ctrl;
  localparam int N     = 2;
  localparam int S     = 4;
  localparam int KW    = 4;
  localparam int DWID  = S * N;
  localparam int DRAIN = 2 * S - 1;

  logic            clk = 1'b0;
  logic            rst;
  logic            start;
  logic [KW-1:0]   k_len;
  logic [DWID-1:0] a_vec, b_vec;
`ifdef SYS_SEQ_STALL_EN
  logic            stall;
`endif
  logic            rd_en, pe_clr, busy, done;
  logic [KW-1:0]   rd_addr;
  logic [DWID-1:0] feed_a, feed_b;

  systolic_seq_ctrl #(.N(N), .S(S), .KW(KW)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .k_len  (k_len),
    .a_vec  (a_vec),
    .b_vec  (b_vec),
`ifdef SYS_SEQ_STALL_EN
    .stall  (stall),
`endif
    .rd_en  (rd_en),
    .rd_addr(rd_addr),
    .feed_a (feed_a),
    .feed_b (feed_b),
    .pe_clr (pe_clr),
    .busy   (busy),
    .done   (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    int              cyc;
    logic [DWID-1:0] a;
    logic [DWID-1:0] b;
  } ev_t;

  ev_t             q_rd[$], q_fd[$], q_clr[$], q_done[$];
  int              cyc = 0;
  int              checks = 0;
  int              errors = 0;
  logic [DWID-1:0] mem_a [16];
  logic [DWID-1:0] mem_b [16];
  logic [127:0]    stall_m;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", name, cyc, act, exp);
    end
  endtask

  task automatic unexpected(input string name);
    checks++;
    errors++;
    $display("FAIL %s cyc=%0d got=event exp=none", name, cyc);
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_rd_en"},   32'(rd_en),   32'd0);
    check({tag, "_rd_addr"}, 32'(rd_addr), 32'd0);
    check({tag, "_feed_a"},  32'(feed_a),  32'd0);
    check({tag, "_feed_b"},  32'(feed_b),  32'd0);
    check({tag, "_pe_clr"},  32'(pe_clr),  32'd0);
    check({tag, "_busy"},    32'(busy),    32'd0);
    check({tag, "_done"},    32'(done),    32'd0);
  endtask

  function automatic logic [DWID-1:0] nz();
    return DWID'($urandom_range(1, (1 << DWID) - 1));
  endfunction

  function automatic bit stalled(input int j);
    return (j >= 0 && j < 128) ? stall_m[j] : 1'b0;
  endfunction

  // Job as a list of timed events: clear at 1, one read per unstalled cycle from 2,
  // data one cycle later, DRAIN unstalled cycles, then done. Events at or after lim are dropped.
  task automatic model_job(input int c, input int k, input int lim, output int done_j);
    int  j, b, d;
    ev_t e;
    e.a = '0;
    e.b = '0;
    if (c + 1 < lim) begin e.cyc = c + 1; q_clr.push_back(e); end
    j = 2;
    b = 0;
    while (b < k) begin
      if (!stalled(j)) begin
        if (c + j < lim) begin
          e.cyc = c + j; e.a = DWID'(b); e.b = '0;
          q_rd.push_back(e);
        end
        if (c + j + 1 < lim) begin
          e.cyc = c + j + 1; e.a = mem_a[b]; e.b = mem_b[b];
          q_fd.push_back(e);
        end
        b++;
      end
      j++;
    end
    d = 0;
    while (d < DRAIN) begin
      if (!stalled(j)) d++;
      j++;
    end
    done_j = j;
    if (c + j < lim) begin e.cyc = c + j; e.a = '0; e.b = '0; q_done.push_back(e); end
  endtask

  // noise: 0 none, 1 random start/k_len while busy, 2 re-pulse start with k_len=7 in cycle 3
  task automatic run_job(input int k, input int abort_j, input int noise);
    int c, done_j, lim, j_end;
    for (int i = 0; i < 16; i++) begin
      mem_a[i] = nz();
      mem_b[i] = nz();
    end
    c      = cyc;
    lim    = (abort_j == 0) ? 32'h3fff_ffff : c + abort_j;
    start  = 1'b1;
    k_len  = KW'(k);
    done_j = 0;
    if (k != 0) model_job(c, k, lim, done_j);
    j_end = (k == 0) ? 4 : ((abort_j != 0) ? abort_j : done_j + 1);
    for (int j = 1; j <= j_end; j++) begin
      @(posedge clk);
      #1;
`ifdef SYS_SEQ_STALL_EN
      stall = stalled(j);
`endif
      if (abort_j != 0 && j == abort_j) begin
        rst = 1'b0;
        #1;
        check_idle("rst_mid");
        @(negedge clk);
        @(negedge clk);
`ifdef SYS_SEQ_STALL_EN
        stall = 1'b0;
`endif
        rst = 1'b1;
      end else begin
        start = 1'b0;
        if (noise == 1 && j <= done_j) begin
          start = 1'($urandom_range(0, 1));
          k_len = KW'($urandom);
        end
        if (noise == 2 && j == 3) begin
          start = 1'b1;
          k_len = KW'(7);
        end
        check("busy", 32'(busy), (k != 0 && j <= done_j) ? 32'd1 : 32'd0);
      end
    end
    start = 1'b0;
`ifdef SYS_SEQ_STALL_EN
    stall = 1'b0;
`endif
  endtask

  // Operand buffer: answers a read one cycle later; otherwise presents nonzero junk so
  // any ungated feed shows up as an unexpected bus value.
  initial begin
    logic          pend;
    logic [KW-1:0] pa;
    a_vec = '0;
    b_vec = '0;
    forever begin
      @(negedge clk);
      pend = rd_en;
      pa   = rd_addr;
      @(posedge clk);
      #1;
      if (pend === 1'b1) begin
        a_vec = mem_a[pa];
        b_vec = mem_b[pa];
      end else begin
        a_vec = nz();
        b_vec = nz();
      end
    end
  end

  always @(negedge clk) begin : monitor
    ev_t e;
    if (rd_en === 1'b1) begin
      if (q_rd.size() == 0) unexpected("rd_en");
      else begin
        e = q_rd.pop_front();
        check("rd_cycle", 32'(cyc), 32'(e.cyc));
        check("rd_addr", 32'(rd_addr), 32'(e.a));
      end
    end
    if (feed_a !== '0 || feed_b !== '0) begin
      if (q_fd.size() == 0) unexpected("feed");
      else begin
        e = q_fd.pop_front();
        check("feed_cycle", 32'(cyc), 32'(e.cyc));
        check("feed_a", 32'(feed_a), 32'(e.a));
        check("feed_b", 32'(feed_b), 32'(e.b));
      end
    end
    if (pe_clr === 1'b1) begin
      if (q_clr.size() == 0) unexpected("pe_clr");
      else begin
        e = q_clr.pop_front();
        check("clr_cycle", 32'(cyc), 32'(e.cyc));
      end
    end
    if (done === 1'b1) begin
      if (q_done.size() == 0) unexpected("done");
      else begin
        e = q_done.pop_front();
        check("done_cycle", 32'(cyc), 32'(e.cyc));
        check("busy_at_done", 32'(busy), 32'd1);
      end
    end
  end

  initial begin
    rst     = 1'b0;
    start   = 1'b0;
    k_len   = '0;
    stall_m = '0;
`ifdef SYS_SEQ_STALL_EN
    stall   = 1'b0;
`endif
    #12;
    check_idle("reset");
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    run_job(3, 0, 0);
    run_job(0, 0, 0);
    run_job(3, 0, 2);
    run_job(3, 8, 0);
    run_job(1, 0, 0);
    run_job(15, 0, 0);
`ifdef SYS_SEQ_STALL_EN
    stall_m[3] = 1'b1;
    stall_m[4] = 1'b1;
    run_job(3, 0, 0);
    stall_m = '0;
`endif
    repeat (12) begin
`ifdef SYS_SEQ_STALL_EN
      stall_m = {$urandom, $urandom, $urandom, $urandom} &
                {$urandom, $urandom, $urandom, $urandom};
`endif
      run_job($urandom_range(1, 15), 0, 1);
    end
    stall_m = '0;
    repeat (4) @(posedge clk);
    #1;
    check("q_rd_left",   32'(q_rd.size()),   32'd0);
    check("q_fd_left",   32'(q_fd.size()),   32'd0);
    check("q_clr_left",  32'(q_clr.size()),  32'd0);
    check("q_done_left", 32'(q_done.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/systolic_seq_ctrl.md
SYSTOLIC_SEQ_CTRL -- requirements
Module: systolic_seq_ctrl

Interface
REQ-001 SHALL have parameter N, default 2, operand element width in bits.
REQ-002 SHALL have parameter S, default 4, systolic array dimension (S x S PEs, S lanes per operand bus).
REQ-003 SHALL have parameter KW, default 4, width of the beat-count and read-address fields.
REQ-004 SHALL have port clk, input, 1, single clock, all state on rising edge.
REQ-005 SHALL have port rst, input, 1, asynchronous active-low reset.
REQ-006 SHALL have port start, input, 1, job request, sampled only in IDLE.
REQ-007 SHALL have port k_len, input, KW, number of operand beats, sampled with start.
REQ-008 SHALL have port a_vec, input, S*N, A column slice from operand buffer, valid one cycle after rd_en.
REQ-009 SHALL have port b_vec, input, S*N, B row slice from operand buffer, valid one cycle after rd_en.
REQ-010 SHALL have port rd_en, output, 1, operand buffer read strobe.
REQ-011 SHALL have port rd_addr, output, KW, beat index being read.
REQ-012 SHALL have port feed_a, output, S*N, A bus to input skew network; zero when not valid.
REQ-013 SHALL have port feed_b, output, S*N, B bus to input skew network; zero when not valid.
REQ-014 SHALL have port pe_clr, output, 1, one-cycle PE accumulator clear.
REQ-015 SHALL have ports busy (out, 1, high outside IDLE) and done (out, 1, one-cycle completion pulse).

Function
REQ-016 SHALL implement FSM IDLE -> CLEAR -> FEED -> DRAIN -> DONE -> IDLE.
REQ-017 IDLE: start=1 and k_len!=0 SHALL latch k_len and go to CLEAR; start with k_len=0 SHALL be ignored.
REQ-018 CLEAR SHALL last exactly one cycle with pe_clr=1, rd_en=0.
REQ-019 FEED SHALL last k_len unstalled cycles, rd_en=1, rd_addr counting 0..k_len-1, no wrap.
REQ-020 feed_a/feed_b SHALL equal a_vec/b_vec in the cycle after each rd_en=1 cycle (registered valid), else all-zero.
REQ-021 DRAIN SHALL last 2*S-1 unstalled cycles starting the cycle after the last rd_en, rd_en=0.
REQ-022 DONE SHALL last one cycle with done=1, busy=1; next cycle IDLE, busy=0.
REQ-023 start while busy SHALL be ignored; changes to k_len after latch SHALL have no effect.
REQ-024 k_len at max value 2^KW-1 SHALL complete correctly with rd_addr reaching 2^KW-2.

Reset
REQ-025 rst low SHALL force IDLE asynchronously, at any point including mid-FEED/DRAIN, with rd_en=0, rd_addr=0, feed_a=0, feed_b=0, pe_clr=0, busy=0, done=0 and the valid pipeline cleared.
REQ-026 After rst release the block SHALL accept start on the first rising edge.

Configuration
REQ-027 Macro SYS_SEQ_STALL_EN defined SHALL add input stall (1 bit): while high in FEED/DRAIN, counters and state hold, rd_en=0, next-cycle feed buses zero; CLEAR and DONE SHALL ignore stall.
REQ-028 Macro undefined SHALL omit the stall port and behave as stall=0.

Structure
REQ-029 Shared package systolic_pkg SHALL hold the FSM state enum and the DRAIN_LEN(S)=2*S-1 constant function.
REQ-030 A sub-module seq_down_cnt (loadable down counter with hold and zero flag) SHALL serve both FEED and DRAIN counts.

Verification (S=4, N=2, KW=4; edge 0 = start sampled)
REQ-031 start=1, k_len=3 -> pe_clr cycle 1; rd_en cycles 2-4, addr 0,1,2; feed valid cycles 3-5; DRAIN cycles 5-11; done cycle 12; busy low cycle 13.
REQ-032 start=1, k_len=0 -> busy stays 0, no rd_en, no done.
REQ-033 start re-pulsed during FEED with k_len=7 -> ignored; original k_len=3 timing unchanged.
REQ-034 rst low during DRAIN cycle 8 -> all outputs zero immediately; after release, start k_len=1 -> done at cycle 10.
REQ-035 k_len=15 -> 15 rd_en cycles, last rd_addr=14, done at cycle 24.
REQ-036 With SYS_SEQ_STALL_EN, k_len=3, stall high cycles 3-4 -> rd_en cycles 2,5,6; done at cycle 14.
